wb_sram16: RTL and testbench



---
 rtl/wb_sram16.sv | 140 ++++++++++++++
 tb/tb_wb_sram16.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram16.sv
// Wishbone slave that maps each 32-bit access onto two 16-bit asynchronous SRAM
// accesses, upper halfword first.
module wb_sram16 #(
  parameter int adr_width = 18,
  parameter int latency   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] sram_adr,
  inout  wire  [15:0]          sram_dat,
  output logic [1:0]           sram_be_n,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, ACK
  } state_t;

  localparam logic [3:0] LAST = 4'(latency - 1);

  state_t               state_reg, state_next;
  logic [adr_width-2:0] word_reg;
  logic                 half_reg;
  logic [31:0]          dat_reg;
  logic [3:0]           sel_reg;
  logic [15:0]          hi_reg;
  logic [3:0]           cnt_reg;
  logic [31:0]          rdat_reg;
  logic                 accept;
  logic                 phase_done;
  logic                 drive;
  logic [1:0]           half_sel;
  logic [15:0]          wr_half;
  logic                 unused_adr;

  assign unused_adr = ^{wb_adr_i[31:adr_width+1], wb_adr_i[1:0]};

  assign accept     = (state_reg == IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign phase_done = (cnt_reg == LAST);
  assign half_sel   = half_reg ? sel_reg[1:0] : sel_reg[3:2];
  assign wr_half    = half_reg ? dat_reg[15:0] : dat_reg[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!wb_we_i)             state_next = RD_HI;
          else if (wb_sel_i == 4'b0) state_next = ACK;
          else                      state_next = WR_SETUP;
        end
      end
      RD_HI:    if (phase_done) state_next = RD_LO;
      RD_LO:    if (phase_done) state_next = ACK;
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (phase_done) state_next = WR_HOLD;
      WR_HOLD:  state_next = (!half_reg && (|sel_reg[1:0])) ? WR_SETUP : ACK;
      ACK:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Phase counter restarts on every state change; a phase ends when it reaches latency-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_reg <= '0;
      half_reg <= 1'b0;
      dat_reg  <= '0;
      sel_reg  <= '0;
      hi_reg   <= '0;
      cnt_reg  <= '0;
      rdat_reg <= '0;
    end else begin
      cnt_reg <= (state_next != state_reg) ? 4'd0 : cnt_reg + 4'd1;
      if (accept) begin
        word_reg <= wb_adr_i[adr_width:2];
        dat_reg  <= wb_dat_i;
        sel_reg  <= wb_sel_i;
        // A write with no upper-half selects starts directly on the lower half.
        half_reg <= wb_we_i && !(|wb_sel_i[3:2]) && (|wb_sel_i[1:0]);
      end
      if (state_reg == RD_HI && phase_done) begin
        hi_reg   <= sram_dat;
        half_reg <= 1'b1;
      end
      if (state_reg == RD_LO && phase_done)
        rdat_reg <= {hi_reg, sram_dat};
      if (state_reg == WR_HOLD && state_next == WR_SETUP)
        half_reg <= 1'b1;
    end
  end

  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = 2'b11;
    drive     = 1'b0;
    case (state_reg)
      RD_HI, RD_LO: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 2'b00;
      end
      WR_SETUP, WR_HOLD: begin
        sram_ce_n = 1'b0;
        sram_be_n = ~half_sel;
        drive     = 1'b1;
      end
      WR_PULSE: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_be_n = ~half_sel;
        drive     = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_dat = drive ? wr_half : 16'hzzzz;
  assign sram_adr = {word_reg, half_reg};
  assign wb_ack_o = (state_reg == ACK);
  assign wb_dat_o = rdat_reg;

endmodule

// File: tb/tb_wb_sram16.sv
// Bench for wb_sram16: two instances (latency 2 and 1) each on a behavioural async SRAM,
// checked against a word-level reference of the bus contents and cycle counts.
module tb_wb_sram16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        req0, req1;
  bit          use1 = 1'b0;

  logic [31:0] dat_o0, dat_o1;
  logic        ack0, ack1;
  logic [17:0] adr0;
  logic [11:0] adr1;
  wire  [15:0] sdat0, sdat1;
  logic [1:0]  be0, be1;
  logic        ce0, oe0, we0, ce1, oe1, we1;

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:4095];
  logic [31:0] ref_mem [int unsigned];

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  logic        ack_m, we_n_m;
  logic [31:0] dat_o_m;
  logic [17:0] adr_m;
  logic [1:0]  be_n_m;

  always #5 clk = ~clk;

  wb_sram16 #(.adr_width(18), .latency(2)) dut0 (
    .clk(clk), .reset(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_o0),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(req0), .wb_stb_i(req0), .wb_ack_o(ack0),
    .sram_adr(adr0), .sram_dat(sdat0), .sram_be_n(be0), .sram_ce_n(ce0), .sram_oe_n(oe0),
    .sram_we_n(we0)
  );

  wb_sram16 #(.adr_width(12), .latency(1)) dut1 (
    .clk(clk), .reset(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_o1),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(req1), .wb_stb_i(req1), .wb_ack_o(ack1),
    .sram_adr(adr1), .sram_dat(sdat1), .sram_be_n(be1), .sram_ce_n(ce1), .sram_oe_n(oe1),
    .sram_we_n(we1)
  );

  // Asynchronous SRAM models: drive on output enable, store bytes while write enable is low.
  assign sdat0 = (!ce0 && !oe0 && we0) ? mem0[adr0] : 16'hzzzz;
  assign sdat1 = (!ce1 && !oe1 && we1) ? mem1[adr1] : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce0 && !we0) begin
      if (!be0[1]) mem0[adr0][15:8] <= sdat0[15:8];
      if (!be0[0]) mem0[adr0][7:0]  <= sdat0[7:0];
    end
    if (!ce1 && !we1) begin
      if (!be1[1]) mem1[adr1][15:8] <= sdat1[15:8];
      if (!be1[0]) mem1[adr1][7:0]  <= sdat1[7:0];
    end
    if ((!oe0 && !we0) || (!oe1 && !we1)) overlap++;
  end

  assign ack_m   = use1 ? ack1 : ack0;
  assign we_n_m  = use1 ? we1 : we0;
  assign dat_o_m = use1 ? dat_o1 : dat_o0;
  assign adr_m   = use1 ? {6'd0, adr1} : adr0;
  assign be_n_m  = use1 ? be1 : be0;

  function automatic int exp_ack(bit we, logic [3:0] sel, int lat);
    int n;
    if (!we) return 1 + 2 * lat;
    n = 0;
    if (|sel[3:2]) n++;
    if (|sel[1:0]) n++;
    return 1 + n * (lat + 2);
  endfunction

  // One bus transaction; cycle 0 is the cycle in which the request is presented.
  task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int ack_cyc, output logic [31:0] rdata,
                         output int pulses, output int wmin, output int wmax,
                         output logic [17:0] p_adr, output logic [1:0] p_be);
    int w;
    @(negedge clk);
    wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    if (use1) req1 = 1'b1; else req0 = 1'b1;
    ack_cyc = -1; rdata = '0; pulses = 0; wmin = 999; wmax = 0; w = 0;
    p_adr = '0; p_be = 2'b11;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!we_n_m) begin
        if (w == 0) begin pulses++; p_adr = adr_m; p_be = be_n_m; end
        w++;
      end else if (w > 0) begin
        if (w < wmin) wmin = w;
        if (w > wmax) wmax = w;
        w = 0;
      end
      if (ack_m) begin ack_cyc = c; rdata = dat_o_m; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    $display("txn dut%0d we=%0b adr=%h dat=%h sel=%b ack_cycle=%0d rdata=%h pulses=%0d",
             use1, we, adr, dat, sel, ack_cyc, rdata, pulses);
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack0); end
    n_checks++; if (dat_o0 !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", dat_o0); end
    n_checks++; if (adr0 !== 18'h0) begin n_fail++; $display("FAIL reset_adr got %h want 0", adr0); end
    n_checks++; if (be0 !== 2'b11) begin n_fail++; $display("FAIL reset_be got %b want 11", be0); end
    n_checks++;
    if ({ce0, oe0, we0} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes got %b want 111", {ce0, oe0, we0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_write;
    int ac, p, wmn, wmx; logic [31:0] rd; logic [17:0] pa; logic [1:0] pb;
    run_txn(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
    ref_mem[32'h40] = 32'hDEADBEEF;
    n_checks++; if (ac != exp_ack(1'b1, 4'b1111, 2)) begin n_fail++; $display("FAIL full_write_ack got %0d want %0d", ac, exp_ack(1'b1, 4'b1111, 2)); end
    n_checks++; if (p != 2) begin n_fail++; $display("FAIL full_write_pulses got %0d want 2", p); end
    n_checks++; if (wmn != 2 || wmx != 2) begin n_fail++; $display("FAIL full_write_width got %0d..%0d want 2", wmn, wmx); end
    n_checks++; if (mem0[18'h80] !== 16'hDEAD) begin n_fail++; $display("FAIL full_write_hi got %h want DEAD", mem0[18'h80]); end
    n_checks++; if (mem0[18'h81] !== 16'hBEEF) begin n_fail++; $display("FAIL full_write_lo got %h want BEEF", mem0[18'h81]); end
    run_txn(1'b0, 32'h100, 32'h0, 4'b0000, ac, rd, p, wmn, wmx, pa, pb);
    n_checks++; if (ac != exp_ack(1'b0, 4'b0000, 2)) begin n_fail++; $display("FAIL full_read_ack got %0d want %0d", ac, exp_ack(1'b0, 4'b0000, 2)); end
    n_checks++; if (rd !== ref_mem[32'h40]) begin n_fail++; $display("FAIL full_read_data got %h want %h", rd, ref_mem[32'h40]); end
  endtask

  task automatic test_partial_write;
    int ac, p, wmn, wmx; logic [31:0] rd; logic [17:0] pa; logic [1:0] pb;
    run_txn(1'b1, 32'h100, 32'h00AA0000, 4'b0100, ac, rd, p, wmn, wmx, pa, pb);
    ref_mem[32'h40][23:16] = 8'hAA;
    n_checks++; if (ac != 5) begin n_fail++; $display("FAIL partial_ack got %0d want 5", ac); end
    n_checks++; if (p != 1) begin n_fail++; $display("FAIL partial_pulses got %0d want 1", p); end
    n_checks++; if (pa !== 18'h80) begin n_fail++; $display("FAIL partial_adr got %h want 080", pa); end
    n_checks++; if (pb !== 2'b10) begin n_fail++; $display("FAIL partial_be got %b want 10", pb); end
    run_txn(1'b0, 32'h100, 32'h0, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
    n_checks++; if (rd !== 32'hDEAABEEF) begin n_fail++; $display("FAIL partial_read got %h want DEAABEEF", rd); end
  endtask

  task automatic test_sel_zero;
    int ac, p, wmn, wmx; logic [31:0] rd; logic [17:0] pa; logic [1:0] pb;
    run_txn(1'b1, 32'h100, 32'h12345678, 4'b0000, ac, rd, p, wmn, wmx, pa, pb);
    n_checks++; if (ac != 1) begin n_fail++; $display("FAIL sel0_ack got %0d want 1", ac); end
    n_checks++; if (p != 0) begin n_fail++; $display("FAIL sel0_pulses got %0d want 0", p); end
    n_checks++; if ({mem0[18'h80], mem0[18'h81]} !== ref_mem[32'h40]) begin n_fail++; $display("FAIL sel0_mem got %h want %h", {mem0[18'h80], mem0[18'h81]}, ref_mem[32'h40]); end
    n_checks++; if (dat_o0 !== 32'hDEAABEEF) begin n_fail++; $display("FAIL sel0_dat_o got %h want DEAABEEF", dat_o0); end
  endtask

  task automatic test_reset_mid_write;
    int ac, p, wmn, wmx, acks; logic [31:0] rd; logic [17:0] pa; logic [1:0] pb; bit seen;
    @(negedge clk);
    wb_we = 1'b1; wb_adr = 32'h180; wb_dat = $urandom; wb_sel = 4'b1111; req0 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!we0) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midreset_pulse got none want we_n low"); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({ce0, oe0, we0, be0} !== 5'b11111) begin n_fail++; $display("FAIL midreset_strobes got %b want 11111", {ce0, oe0, we0, be0}); end
    req0 = 1'b0;
    acks = 0;
    repeat (2) begin @(negedge clk); if (ack0) acks++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (ack0) acks++; end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL midreset_ack got %0d want 0", acks); end
    run_txn(1'b0, 32'h100, 32'h0, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
    n_checks++; if (ac != 5) begin n_fail++; $display("FAIL midreset_read_ack got %0d want 5", ac); end
    n_checks++; if (rd !== ref_mem[32'h40]) begin n_fail++; $display("FAIL midreset_read_data got %h want %h", rd, ref_mem[32'h40]); end
  endtask

  task automatic test_back_to_back;
    int ac, p, wmn, wmx, n; int cyc[2]; logic [31:0] got[2]; logic [31:0] rd, da, db;
    logic [17:0] pa; logic [1:0] pb;
    da = $urandom; db = $urandom;
    run_txn(1'b1, 32'h0, da, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
    run_txn(1'b1, 32'h4, db, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
    overlap = 0;
    @(negedge clk);
    wb_we = 1'b0; wb_adr = 32'h0; wb_sel = 4'b1111; req0 = 1'b1;
    n = 0; cyc[0] = -1; cyc[1] = -1; got[0] = '0; got[1] = '0;
    for (int c = 1; c <= 40 && n < 2; c++) begin
      @(negedge clk);
      if (ack0) begin
        cyc[n] = c; got[n] = dat_o0; n++;
        wb_adr = 32'h4;
        $display("txn dut0 back-to-back read ack_cycle=%0d rdata=%h", c, dat_o0);
      end
    end
    req0 = 1'b0;
    n_checks++; if (cyc[0] != 5) begin n_fail++; $display("FAIL b2b_ack0 got %0d want 5", cyc[0]); end
    n_checks++; if (cyc[1] != 11) begin n_fail++; $display("FAIL b2b_ack1 got %0d want 11", cyc[1]); end
    n_checks++; if (got[0] !== da) begin n_fail++; $display("FAIL b2b_data0 got %h want %h", got[0], da); end
    n_checks++; if (got[1] !== db) begin n_fail++; $display("FAIL b2b_data1 got %h want %h", got[1], db); end
    n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL b2b_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_latency1;
    int ac, p, wmn, wmx; logic [31:0] rd; logic [17:0] pa; logic [1:0] pb;
    use1 = 1'b1;
    run_txn(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
    n_checks++; if (ac != 7) begin n_fail++; $display("FAIL lat1_write_ack got %0d want 7", ac); end
    n_checks++; if (p != 2 || wmn != 1 || wmx != 1) begin n_fail++; $display("FAIL lat1_pulses got %0d x %0d..%0d want 2 x 1", p, wmn, wmx); end
    n_checks++; if ({mem1[12'h80], mem1[12'h81]} !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat1_mem got %h want DEADBEEF", {mem1[12'h80], mem1[12'h81]}); end
    run_txn(1'b0, 32'h100, 32'h0, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
    n_checks++; if (ac != 3) begin n_fail++; $display("FAIL lat1_read_ack got %0d want 3", ac); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat1_read_data got %h want DEADBEEF", rd); end
    use1 = 1'b0;
  endtask

  task automatic test_random;
    int ac, p, wmn, wmx, halves; logic [31:0] rd, d; logic [17:0] pa; logic [1:0] pb;
    logic [3:0] sel; bit we; int unsigned idx, key;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      run_txn(1'b1, 32'h2000 + 32'(4 * i), d, 4'b1111, ac, rd, p, wmn, wmx, pa, pb);
      ref_mem[32'h800 + i] = d;
    end
    for (int t = 0; t < 40; t++) begin
      idx = $urandom_range(0, 15); key = 32'h800 + idx;
      we = 1'($urandom); sel = 4'($urandom); d = $urandom;
      run_txn(we, 32'h2000 + 4 * idx, d, sel, ac, rd, p, wmn, wmx, pa, pb);
      n_checks++; if (ac != exp_ack(we, sel, 2)) begin n_fail++; $display("FAIL rand_ack t=%0d got %0d want %0d", t, ac, exp_ack(we, sel, 2)); end
      if (we) begin
        halves = 0;
        if (|sel[3:2]) halves++;
        if (|sel[1:0]) halves++;
        for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[key][b*8 +: 8] = d[b*8 +: 8];
        n_checks++; if (p != halves) begin n_fail++; $display("FAIL rand_pulses t=%0d got %0d want %0d", t, p, halves); end
      end else begin
        n_checks++; if (rd !== ref_mem[key]) begin n_fail++; $display("FAIL rand_read t=%0d got %h want %h", t, rd, ref_mem[key]); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_sel_zero();
    test_reset_mid_write();
    test_back_to_back();
    test_latency1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
